// File: rtl/polaris_uart_rx_os.sv
// Oversampling UART receive front end: synchronises the serial line, rejects start glitches,
// optionally checks parity and flags framing errors and breaks, producing one write strobe per byte.
module polaris_uart_rx_os #(
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_EN   = 1'b0,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic        lsioc_clk_i,
  input  logic        lsioc_rst_i,
  input  logic [11:0] clktobaudrate,
  input  logic        rx_en,
  input  logic        uart_rx_i,
  output logic        rx_vld,
  output logic [7:0]  rx_byte,
  output logic        parity_err,
  output logic        frame_err,
  output logic        break_det,
  output logic        rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic        rxs;
  logic [11:0] n_eff, n_m1, half_m1;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_bit_q, par_bit_d;
  logic        par_bad, sample;
  logic [7:0]  byte_q, byte_d;
  logic        vld_q, vld_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge lsioc_clk_i or negedge lsioc_rst_i) begin
    if (!lsioc_rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
    end
  end

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign n_eff   = (clktobaudrate < 12'd4) ? 12'd4 : clktobaudrate;
  assign n_m1    = n_eff - 12'd1;
  assign half_m1 = {1'b0, n_eff[11:1]} - 12'd1;
  assign sample  = (cnt_q == 12'd0);
  assign par_bad = PARITY_EN && ((^shift_q ^ par_bit_q) != PARITY_ODD);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q - 12'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    byte_d    = byte_q;
    vld_d     = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    brk_d     = 1'b0;
    if (!rx_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            cnt_d   = half_m1;
            state_d = START;
          end
        end
        START: begin
          if (sample) begin
            if (rxs) begin
              state_d = IDLE;
            end else begin
              cnt_d     = n_m1;
              bit_idx_d = 3'd0;
              state_d   = DATA;
            end
          end
        end
        DATA: begin
          if (sample) begin
            cnt_d     = n_m1;
            shift_d   = {rxs, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (sample) begin
            cnt_d     = n_m1;
            par_bit_d = rxs;
            state_d   = STOP;
          end
        end
        STOP: begin
          // A low stop bit is a break only when every sampled bit of the character was low.
          if (sample) begin
            if (rxs) begin
              vld_d   = 1'b1;
              byte_d  = shift_q;
              perr_d  = par_bad;
              state_d = IDLE;
            end else if ((shift_q == 8'h00) && (!PARITY_EN || !par_bit_q)) begin
              brk_d   = 1'b1;
              state_d = WAIT_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rxs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge lsioc_clk_i or negedge lsioc_rst_i) begin
    if (!lsioc_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      byte_q    <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      byte_q    <= byte_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
    end
  end

  assign rx_vld     = vld_q;
  assign rx_byte    = byte_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_polaris_uart_rx_os.sv
// Bench for polaris_uart_rx_os: an 8N1 and an 8E1 instance share one serial line; their pulses
// are checked against fixed vectors and against a frame decoder working on the recorded line.
module tb_polaris_uart_rx_os;
  localparam int SYNC  = 2;
  localparam int MAXC  = 30000;
  localparam int K_VLD = 1;
  localparam int K_FE  = 2;
  localparam int K_BRK = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
    logic       perr;
  } event_t;

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         with_par;
    bit         par_bit;
    bit         stop_bit;
    int         inst;
    int         exp_kind;
    logic [7:0] exp_byte;
    bit         exp_perr;
    int         exp_off;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] baud = 12'd16;
  logic        rx_en = 1'b0;
  logic        line = 1'b1;
  logic        vld0, perr0, ferr0, brk0, busy0;
  logic        vld1, perr1, ferr1, brk1, busy1;
  logic [7:0]  byte0, byte1;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          inv_viol = 0;
  logic        hist_line  [0:MAXC-1];
  logic        hist_en    [0:MAXC-1];
  logic [11:0] hist_baud  [0:MAXC-1];
  logic        hist_busy0 [0:MAXC-1];
  logic        hist_busy1 [0:MAXC-1];
  logic [7:0]  last_byte  [0:1];
  event_t      act0[$];
  event_t      act1[$];
  event_t      exp_q[$];
  event_t      sel_q[$];

  polaris_uart_rx_os #(.SYNC_STAGES(SYNC), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .lsioc_clk_i(clk), .lsioc_rst_i(rst_n), .clktobaudrate(baud), .rx_en(rx_en),
    .uart_rx_i(line), .rx_vld(vld0), .rx_byte(byte0), .parity_err(perr0),
    .frame_err(ferr0), .break_det(brk0), .rx_busy(busy0));

  polaris_uart_rx_os #(.SYNC_STAGES(SYNC), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .lsioc_clk_i(clk), .lsioc_rst_i(rst_n), .clktobaudrate(baud), .rx_en(rx_en),
    .uart_rx_i(line), .rx_vld(vld1), .rx_byte(byte1), .parity_err(perr1),
    .frame_err(ferr1), .break_det(brk1), .rx_busy(busy1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void mon(int inst, logic v, logic [7:0] b, logic pe, logic fe, logic bk);
    event_t ev;
    if ((32'(v) + 32'(fe) + 32'(bk)) > 32'd1) inv_viol++;
    if (pe && !v) inv_viol++;
    if (!v && (b !== last_byte[inst])) inv_viol++;
    if (v) last_byte[inst] = b;
    if (v || fe || bk) begin
      ev.cyc  = cyc;
      ev.kind = v ? K_VLD : (fe ? K_FE : K_BRK);
      ev.data = b;
      ev.perr = pe;
      if (inst == 0) act0.push_back(ev);
      else act1.push_back(ev);
    end
  endfunction

  // Everything is recorded mid-cycle, indexed by the number of rising edges seen so far.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      hist_line[cyc]  <= line;
      hist_en[cyc]    <= rx_en;
      hist_baud[cyc]  <= baud;
      hist_busy0[cyc] <= busy0;
      hist_busy1[cyc] <= busy1;
    end
    if (!rst_n) begin
      last_byte[0] = 8'h00;
      last_byte[1] = 8'h00;
    end else begin
      mon(0, vld0, byte0, perr0, ferr0, brk0);
      mon(1, vld1, byte1, perr1, ferr1, brk1);
    end
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int neff(logic [11:0] b);
    return (b < 12'd4) ? 4 : int'(b);
  endfunction

  function automatic logic rxs_at(int c);
    if (c - SYNC < 0) return 1'b1;
    return hist_line[c - SYNC];
  endfunction

  function automatic int first_en_low(int a, int b);
    for (int y = a; y <= b; y++) if (!hist_en[y]) return y;
    return -1;
  endfunction

  function automatic logic busy_at(int inst, int c);
    return (inst == 0) ? hist_busy0[c] : hist_busy1[c];
  endfunction

  // Decodes the recorded line as the receiver should: start found at D, samples at D+H then every N.
  function automatic void run_model(int inst, int s, int e);
    int c, t, prev, x, w, nsamp;
    logic [7:0] d;
    logic pb, sb, v;
    bit par_en, aborted;
    event_t ev;
    par_en = (inst == 1);
    nsamp  = par_en ? 11 : 10;
    exp_q.delete();
    c = s;
    while (c < e) begin
      if (!hist_en[c] || rxs_at(c)) begin
        c++;
      end else begin
        prev = c;
        t = c + neff(hist_baud[c]) / 2;
        aborted = 0; d = 8'h00; pb = 1'b0; sb = 1'b0;
        for (int i = 0; i < nsamp && !aborted; i++) begin
          if (t >= e) begin
            aborted = 1; c = e;
          end else begin
            x = first_en_low(prev + 1, t);
            if (x >= 0) begin
              aborted = 1; c = x;
            end else begin
              v = rxs_at(t);
              if (i == 0) begin
                if (v) begin aborted = 1; c = t + 1; end
              end else if (i <= 8) d[i-1] = v;
              else if (i == nsamp - 1) sb = v;
              else pb = v;
              prev = t;
              t = t + neff(hist_baud[t]);
            end
          end
        end
        if (!aborted) begin
          ev.cyc = prev + 1; ev.data = d; ev.perr = 1'b0;
          if (sb) begin
            ev.kind = K_VLD;
            ev.perr = par_en && ((^d ^ pb) != 1'b0);
            c = prev + 1;
          end else begin
            ev.kind = ((d == 8'h00) && (!par_en || !pb)) ? K_BRK : K_FE;
            w = prev + 1;
            while (w < e && hist_en[w] && !rxs_at(w)) w++;
            c = w + 1;
          end
          exp_q.push_back(ev);
        end
      end
    end
  endfunction

  function automatic void collect(int inst, int s, int e);
    sel_q.delete();
    if (inst == 0) begin
      foreach (act0[i]) if (act0[i].cyc >= s && act0[i].cyc < e) sel_q.push_back(act0[i]);
    end else begin
      foreach (act1[i]) if (act1[i].cyc >= s && act1[i].cyc < e) sel_q.push_back(act1[i]);
    end
  endfunction

  task automatic compare_window(input string tag, input int inst, input int s, input int e);
    run_model(inst, s, e);
    collect(inst, s, e);
    check_output({tag, " event count"}, sel_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sel_q.size(); i++) begin
      check_output({tag, " event cycle"}, sel_q[i].cyc, exp_q[i].cyc);
      check_output({tag, " event kind"}, sel_q[i].kind, exp_q[i].kind);
      if (exp_q[i].kind == K_VLD) begin
        check_output({tag, " byte"}, sel_q[i].data, exp_q[i].data);
        check_output({tag, " parity_err"}, sel_q[i].perr, exp_q[i].perr);
      end
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input bit with_par, input bit pb,
                                input bit sb, input int stop_len, output int k);
    int n;
    n = neff(baud);
    k = cyc;
    line = 1'b0;
    tick(n);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      tick(n);
    end
    if (with_par) begin
      line = pb;
      tick(n);
    end
    line = sb;
    tick(n * stop_len);
    line = 1'b1;
  endtask

  function automatic vec_t mk(string nm, logic [7:0] d, bit wp, bit pb, bit sb, int inst,
                              int kind, logic [7:0] eb, bit ep, int off);
    vec_t v;
    v.name = nm; v.data = d; v.with_par = wp; v.par_bit = pb; v.stop_bit = sb; v.inst = inst;
    v.exp_kind = kind; v.exp_byte = eb; v.exp_perr = ep; v.exp_off = off;
    return v;
  endfunction

  initial begin
    vec_t vecs[6];
    int k, k2, d, s, e, n, nf;
    logic [7:0] rb;
    bit wp, pb, sb;

    vecs[0] = mk("a5_8n1",      8'hA5, 0, 0, 1, 0, K_VLD, 8'hA5, 0, 153);
    vecs[1] = mk("3c_stop_low", 8'h3C, 0, 0, 0, 0, K_FE,  8'hA5, 0, 153);
    vecs[2] = mk("55_after_fe", 8'h55, 0, 0, 1, 0, K_VLD, 8'h55, 0, 153);
    vecs[3] = mk("07_par_good", 8'h07, 1, 1, 1, 1, K_VLD, 8'h07, 0, 169);
    vecs[4] = mk("07_par_bad",  8'h07, 1, 0, 1, 1, K_VLD, 8'h07, 1, 169);
    vecs[5] = mk("brk_par",     8'h00, 1, 0, 0, 1, K_BRK, 8'h07, 0, 169);

    tick(5);
    check_output("reset rx_busy", busy0, 0);
    check_output("reset rx_vld", vld0, 0);
    check_output("reset rx_byte", byte0, 0);
    check_output("reset frame_err", ferr0, 0);
    check_output("reset break_det", brk0, 0);
    check_output("reset parity_err", perr0, 0);
    check_output("reset rx_busy parity inst", busy1, 0);
    rst_n = 1'b1;
    tick(3);
    rx_en = 1'b1;
    tick(4);

    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].data, vecs[v].with_par, vecs[v].par_bit, vecs[v].stop_bit, 1, k);
      tick(64);
      d = k + SYNC;
      collect(vecs[v].inst, k, cyc);
      check_output({vecs[v].name, " pulses"}, sel_q.size(), 1);
      if (sel_q.size() > 0) begin
        check_output({vecs[v].name, " kind"}, sel_q[0].kind, vecs[v].exp_kind);
        check_output({vecs[v].name, " offset"}, sel_q[0].cyc - d, vecs[v].exp_off);
        check_output({vecs[v].name, " rx_byte"}, sel_q[0].data, vecs[v].exp_byte);
        check_output({vecs[v].name, " parity_err"}, sel_q[0].perr, vecs[v].exp_perr);
      end
      if (vecs[v].exp_kind == K_VLD) begin
        check_output({vecs[v].name, " busy before pulse"},
                     busy_at(vecs[v].inst, d + vecs[v].exp_off - 1), 1);
        check_output({vecs[v].name, " busy at pulse"},
                     busy_at(vecs[v].inst, d + vecs[v].exp_off), 0);
      end
      compare_window({vecs[v].name, " model 8n1"}, 0, k, cyc);
      compare_window({vecs[v].name, " model 8e1"}, 1, k, cyc);
    end

    // Start glitch shorter than half a bit.
    k = cyc;
    line = 1'b0;
    tick(5);
    line = 1'b1;
    tick(40);
    d = k + SYNC;
    check_output("glitch busy at D", busy_at(0, d), 0);
    check_output("glitch busy at D+1", busy_at(0, d + 1), 1);
    check_output("glitch busy at D+8", busy_at(0, d + 8), 1);
    check_output("glitch busy at D+9", busy_at(0, d + 9), 0);
    check_output("glitch busy 8e1 at D+9", busy_at(1, d + 9), 0);
    compare_window("glitch model 8n1", 0, k, cyc);
    compare_window("glitch model 8e1", 1, k, cyc);

    // Line held low for 20 bit times.
    apply_stimulus(8'h00, 0, 0, 0, 11, k);
    tick(64);
    d = k + SYNC;
    collect(0, k, cyc);
    check_output("break pulses", sel_q.size(), 1);
    if (sel_q.size() > 0) begin
      check_output("break kind", sel_q[0].kind, K_BRK);
      check_output("break offset", sel_q[0].cyc - d, 153);
    end
    check_output("break busy while low", busy_at(0, d + 320), 1);
    check_output("break busy after rise", busy_at(0, d + 321), 0);
    compare_window("break model 8n1", 0, k, cyc);
    compare_window("break model 8e1", 1, k, cyc);

    // Clamped divisor, back-to-back frames.
    baud = 12'd2;
    tick(2);
    s = cyc;
    apply_stimulus(8'h00, 0, 0, 1, 1, k);
    apply_stimulus(8'hFF, 0, 0, 1, 1, k2);
    tick(40);
    collect(0, s, cyc);
    check_output("n4 pulses", sel_q.size(), 2);
    if (sel_q.size() == 2) begin
      check_output("n4 first byte", sel_q[0].data, 8'h00);
      check_output("n4 first offset", sel_q[0].cyc - (k + SYNC), 39);
      check_output("n4 second byte", sel_q[1].data, 8'hFF);
      check_output("n4 second offset", sel_q[1].cyc - (k2 + SYNC), 39);
    end
    compare_window("n4 model 8n1", 0, s, cyc);
    compare_window("n4 model 8e1", 1, s, cyc);

    // Enable dropped mid-frame, restored while idle, then a clean frame.
    s = cyc;
    fork
      apply_stimulus(8'hE1, 0, 0, 1, 1, k);
      begin
        tick(15);
        rx_en = 1'b0;
      end
    join
    tick(10);
    rx_en = 1'b1;
    tick(4);
    apply_stimulus(8'h96, 0, 0, 1, 1, k);
    tick(20);
    collect(0, s, cyc);
    check_output("en drop pulses", sel_q.size(), 1);
    if (sel_q.size() > 0) check_output("en drop restart byte", sel_q[0].data, 8'h96);
    compare_window("en drop model 8n1", 0, s, cyc);
    compare_window("en drop model 8e1", 1, s, cyc);

    // Randomised traffic at random divisors, decoded by the model.
    for (int b = 0; b < 6; b++) begin
      baud = 12'($urandom_range(0, 20));
      n = neff(baud);
      tick(2);
      s = cyc;
      for (int f = 0; f < 7; f++) begin
        if ($urandom_range(0, 7) == 0) begin
          line = 1'b0;
          tick($urandom_range(1, 6));
          line = 1'b1;
          tick($urandom_range(n, 2 * n));
        end
        rb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        wp = 1'($urandom_range(0, 1));
        pb = 1'($urandom);
        sb = ($urandom_range(0, 5) != 0);
        nf = sb ? 1 : $urandom_range(1, 3);
        apply_stimulus(rb, wp, pb, sb, nf, k);
        tick($urandom_range(0, 2 * n));
      end
      line = 1'b1;
      tick(15 * n);
      compare_window("random model 8n1", 0, s, cyc);
      compare_window("random model 8e1", 1, s, cyc);
    end

    // Asynchronous reset in the middle of a frame.
    baud = 12'd16;
    tick(2);
    apply_stimulus(8'h5A, 0, 0, 1, 1, k);
    tick(64);
    check_output("pre-reset rx_byte", byte0, 8'h5A);
    fork
      apply_stimulus(8'hC3, 0, 0, 1, 1, k);
      begin
        tick(60);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async reset rx_busy", busy0, 0);
        check_output("async reset rx_byte", byte0, 0);
        check_output("async reset rx_busy 8e1", busy1, 0);
      end
    join
    tick(2);
    rst_n = 1'b1;
    s = cyc;
    tick(200);
    collect(0, s, cyc);
    check_output("post-reset pulses 8n1", sel_q.size(), 0);
    collect(1, s, cyc);
    check_output("post-reset pulses 8e1", sel_q.size(), 0);

    check_output("pulse/byte invariants", inv_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/polaris_uart_rx_os.md
Name: polaris_uart_rx_os

Overview:
- Oversampling UART receive front end for the LSI UART peripheral. It converts the asynchronous serial line into bytes.
- It sits directly upstream of the 32-entry receive FIFO. Its rx_vld/rx_byte pair drives the FIFO write port, gated by rx_en.
- Beyond basic receive, it adds input synchronisation, start-bit glitch rejection, optional parity checking, and framing-error and break detection.
- Bit timing comes from the shared clktobaudrate divisor, in clock cycles per bit.

Parameters:
- SYNC_STAGES, 2, number of flops in the uart_rx_i synchroniser (minimum 2).
- PARITY_EN, 0, when 1 a parity bit is expected between the last data bit and the stop bit.
- PARITY_ODD, 0, when 1 odd parity is checked, otherwise even (ignored if PARITY_EN=0).

Ports:
- lsioc_clk_i  in  1  peripheral clock.
- lsioc_rst_i  in  1  reset, asynchronous, active-low.
- clktobaudrate  in  12  clock cycles per bit.
- rx_en  in  1  receiver enable.
- uart_rx_i  in  1  asynchronous serial input, idle high.
- rx_vld  out  1  one-cycle pulse: rx_byte valid; this is the FIFO write strobe.
- rx_byte  out  8  received byte, LSB first on the wire.
- parity_err  out  1  qualifies rx_vld: parity mismatch on this byte.
- frame_err  out  1  one-cycle pulse: stop bit sampled low with non-zero data.
- break_det  out  1  one-cycle pulse: all-zero character including stop (and parity) bit.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, rx_byte 8'h00. Synchroniser flops reset to 1 (line idle), so reset never produces a false start.
- Synchronised line: rxs is the output of the SYNC_STAGES flop chain.
- Effective divisor: N = max(clktobaudrate, 4). H = N>>1.
- Bit counter: 12-bit, decrements every cycle. A sample occurs in the cycle the counter reads 0. After each sample the counter reloads with N-1, so sample spacing is exactly N cycles.
- A clktobaudrate change takes effect at the next counter load.
- IDLE: if rx_en and rxs==0, load counter with H-1 and go to START. The cycle of this transition is the detection cycle D.
- START: sample at D+H.
  - rxs==1: glitch, return to IDLE, no output.
  - rxs==0: reload, clear bit index, go to DATA.
- DATA: sample 8 bits at D+H+kN, k=1..8, shifting in LSB first. After bit 7, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample at D+H+9N.
  - parity_bad = (XOR of data bits ^ sampled bit) != PARITY_ODD.
  - Go to STOP.
- STOP: sampled at D+H+(9+PARITY_EN)N.
  - rxs==1: in the next cycle, rx_vld=1, rx_byte=data and parity_err=parity_bad. Go to IDLE. A new start is detectable in that same next cycle.
  - rxs==0, data==0 and sampled parity bit==0 (when enabled): break_det pulses in the next cycle. Go to WAIT_IDLE.
  - rxs==0 otherwise: frame_err pulses in the next cycle. Go to WAIT_IDLE.
  - rx_vld is never asserted for a framing error or a break.
- WAIT_IDLE: remain until rxs==1, then go to IDLE. This prevents a held-low line from retriggering.
- rx_byte holds its last delivered value between pulses. parity_err is 0 whenever rx_vld is 0.
- rx_en deasserted in any state: next state IDLE, counter cleared, no pulses. rx_en is level-checked every cycle.
- Asynchronous reset mid-frame: immediate return to reset values; a partial byte is discarded.
- Pulses are single-cycle, and at most one of rx_vld, frame_err, break_det is high in any cycle.
- No back-pressure: the downstream FIFO drops on full, and overflow is the FIFO's concern.

Test Plan:
- N=16, PARITY_EN=0, send 8'hA5 framed 8N1 -> exactly one rx_vld pulse at D+153, rx_byte=8'hA5, no error pulses, rx_busy back to 0 at D+153.
- N=16, uart_rx_i low for 5 cycles then high -> START rejects the glitch at D+8, no pulses, state returns to IDLE.
- N=16, send 8'h3C with the stop bit low, line high afterwards -> frame_err pulse at D+153, no rx_vld, next frame 8'h55 received correctly.
- N=16, hold line low for 20 bit times -> a single break_det pulse, rx_busy held until the line rises, then IDLE.
- PARITY_EN=1, PARITY_ODD=0, send 8'h07: parity bit 1 -> rx_vld with parity_err=0; parity bit 0 -> rx_vld with parity_err=1, rx_byte=8'h07.
- clktobaudrate=2 (clamped to N=4), back-to-back frames 8'h00, 8'hFF -> both delivered in order; rx_en dropped mid-frame -> no pulse and a clean restart on the next start bit.
